// File: rtl/lsu_ctrl_if.sv
// Data-memory request/response bus between the load/store sequencer and memory.
// The master drives the request fields; the slave returns ack and read data.
interface lsu_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, byte enables, store replication, req/ack handshake
// with timeout, pipeline stall, and latching of the raw load word for the extension unit.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        st_type,
  input  logic [2:0]        ld_op,
  lsu_ctrl_if.master        dm,
  output logic              stall,
  output logic [31:0]       xext_dmout,
  output logic [1:0]        xext_addr,
  output logic [2:0]        xext_op,
  output logic              ld_valid,
  output logic              adel,
  output logic              ades,
  output logic              bus_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lo_q, lo_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       dmout_q, dmout_d;
  logic [1:0]        xaddr_q, xaddr_d;
  logic [2:0]        xop_q, xop_d;
  logic              ld_valid_q, ld_valid_d;
  logic              bus_err_q, bus_err_d;

  logic idle, is_ld, start, timeout;

  always_comb begin
    idle  = (state_q == StIdle);
    // A simultaneous read and write is treated as a store.
    is_ld = mem_read & ~mem_write;
    ades  = idle & mem_write & (((st_type == 2'd0) & (addr[1:0] != 2'b00)) |
                                ((st_type == 2'd2) & addr[0]) |
                                (st_type == 2'd3));
    adel  = idle & is_ld & ((((ld_op == 3'd0) | (ld_op >= 3'd5)) & (addr[1:0] != 2'b00)) |
                            (((ld_op == 3'd3) | (ld_op == 3'd4)) & addr[0]));
    start   = idle & (mem_read | mem_write) & ~adel & ~ades;
    stall   = start | (state_q == StBusy);
    timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    op_d       = op_q;
    dmout_d    = dmout_q;
    xaddr_d    = xaddr_q;
    xop_d      = xop_q;
    ld_valid_d = 1'b0;
    bus_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {addr[31:2], 2'b00};
          cnt_d   = '0;
          lo_d    = addr[1:0];
          op_d    = mem_write ? 3'd0 : ld_op;
          if (mem_write && st_type == 2'd1) begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
          end else if (mem_write && st_type == 2'd2) begin
            be_d    = 4'b0011 << {addr[1], 1'b0};
            wdata_d = {2{wdata[15:0]}};
          end else begin
            be_d    = 4'b1111;
            wdata_d = wdata;
          end
        end
      end
      StBusy: begin
        if (dm.dm_ack) begin
          state_d    = StDone;
          req_d      = 1'b0;
          dmout_d    = we_q ? 32'd0 : dm.dm_rdata;
          xaddr_d    = lo_q;
          xop_d      = op_q;
          ld_valid_d = ~we_q;
        end else if (timeout) begin
          state_d   = StDone;
          req_d     = 1'b0;
          dmout_d   = 32'd0;
          xaddr_d   = lo_q;
          xop_d     = 3'd0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      lo_q       <= '0;
      op_q       <= '0;
      dmout_q    <= '0;
      xaddr_q    <= '0;
      xop_q      <= '0;
      ld_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      op_q       <= op_d;
      dmout_q    <= dmout_d;
      xaddr_q    <= xaddr_d;
      xop_q      <= xop_d;
      ld_valid_q <= ld_valid_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dm.dm_req    = req_q;
  assign dm.dm_we     = we_q;
  assign dm.dm_addr   = addr_q;
  assign dm.dm_be     = be_q;
  assign dm.dm_wdata  = wdata_q;
  assign xext_dmout   = dmout_q;
  assign xext_addr    = xaddr_q;
  assign xext_op      = xop_q;
  assign ld_valid     = ld_valid_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus random transactions against a
// transaction-level model of the expected bus fields, stall length and load result.
module tb_lsu_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [1:0]  st_type;
  logic [2:0]  ld_op;
  logic        stall, ld_valid, adel, ades, bus_err;
  logic [31:0] xext_dmout;
  logic [1:0]  xext_addr;
  logic [2:0]  xext_op;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT_CYC(T), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .st_type    (st_type),
    .ld_op      (ld_op),
    .dm         (bus),
    .stall      (stall),
    .xext_dmout (xext_dmout),
    .xext_addr  (xext_addr),
    .xext_op    (xext_op),
    .ld_valid   (ld_valid),
    .adel       (adel),
    .ades       (ades),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected state of the latched load-result outputs.
  logic [31:0] exp_dmout;
  logic [1:0]  exp_xaddr;
  logic [2:0]  exp_xop;
  bit          xaddr_ok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_xext();
    check_eq("xext_dmout", xext_dmout, exp_dmout);
    check_eq("xext_op", {29'd0, xext_op}, {29'd0, exp_xop});
    if (xaddr_ok) check_eq("xext_addr", {30'd0, xext_addr}, {30'd0, exp_xaddr});
  endtask

  task automatic idle_cycle(input logic ack);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    bus.dm_ack = ack; bus.dm_rdata = $urandom;
    #1;
    check_eq("idle_stall", {31'd0, stall}, 32'd0);
    check_eq("idle_req", {31'd0, bus.dm_req}, 32'd0);
    check_eq("idle_ldv", {31'd0, ld_valid}, 32'd0);
    check_eq("idle_berr", {31'd0, bus_err}, 32'd0);
    check_xext();
  endtask

  // wait_n: BUSY cycles before the ack; wait_n >= T means memory never answers.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] st, input logic [2:0] op,
                         input int wait_n, input logic [31:0] rdat);
    logic        is_ld, e_ades, e_adel, ack;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    bit          tout;
    int          busy_n;
    if (!rd && !wr) begin
      idle_cycle(1'b0);
      return;
    end
    is_ld  = rd && !wr;
    e_ades = wr && ((st == 0 && a[1:0] != 0) || (st == 2 && a[0]) || st == 3);
    e_adel = is_ld && ((((op == 0) || (op >= 5)) && a[1:0] != 0) ||
                       (((op == 3) || (op == 4)) && a[0]));
    if (wr && st == 1) begin
      ebe = 4'b0001 << a[1:0];
      ewd = wd[7:0] * 32'h0101_0101;
    end else if (wr && st == 2) begin
      ebe = a[1] ? 4'b1100 : 4'b0011;
      ewd = wd[15:0] * 32'h0001_0001;
    end else begin
      ebe = 4'b1111;
      ewd = wd;
    end
    tout   = (wait_n >= T);
    busy_n = tout ? T : wait_n + 1;

    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; st_type = st; ld_op = op;
    bus.dm_ack = 1'b0;
    #1;
    check_eq("ades", {31'd0, ades}, {31'd0, e_ades});
    check_eq("adel", {31'd0, adel}, {31'd0, e_adel});
    check_eq("req_idle", {31'd0, bus.dm_req}, 32'd0);
    if (e_ades || e_adel) begin
      check_eq("err_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      check_eq("err_noreq", {31'd0, bus.dm_req}, 32'd0);
      check_xext();
      return;
    end
    check_eq("start_stall", {31'd0, stall}, 32'd1);

    for (int k = 0; k < busy_n; k++) begin
      @(negedge clk);
      ack = (!tout && k == wait_n);
      bus.dm_ack   = ack;
      bus.dm_rdata = ack ? rdat : $urandom;
      #1;
      check_eq("busy_req", {31'd0, bus.dm_req}, 32'd1);
      check_eq("busy_stall", {31'd0, stall}, 32'd1);
      check_eq("dm_we", {31'd0, bus.dm_we}, {31'd0, wr});
      check_eq("dm_addr", bus.dm_addr, {a[31:2], 2'b00});
      check_eq("dm_be", {28'd0, bus.dm_be}, {28'd0, ebe});
      if (wr) check_eq("dm_wdata", bus.dm_wdata, ewd);
    end

    @(negedge clk);
    bus.dm_ack = 1'b0;
    #1;
    if (tout) begin
      exp_dmout = 32'd0; exp_xop = 3'd0; xaddr_ok = 1'b0;
    end else begin
      exp_dmout = wr ? 32'd0 : rdat;
      exp_xop   = wr ? 3'd0 : op;
      exp_xaddr = a[1:0]; xaddr_ok = 1'b1;
    end
    check_eq("done_stall", {31'd0, stall}, 32'd0);
    check_eq("done_req", {31'd0, bus.dm_req}, 32'd0);
    check_eq("ld_valid", {31'd0, ld_valid}, {31'd0, (is_ld && !tout)});
    check_eq("bus_err", {31'd0, bus_err}, {31'd0, tout});
    check_xext();
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; st_type = '0; ld_op = '0;
    bus.dm_ack = 1'b0; bus.dm_rdata = '0;
    exp_dmout = '0; exp_xaddr = '0; exp_xop = '0; xaddr_ok = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req", {31'd0, bus.dm_req}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_ldv", {31'd0, ld_valid}, 32'd0);
    check_eq("rst_berr", {31'd0, bus_err}, 32'd0);
    check_xext();
    reset = 1'b0;

    // lb, immediate ack
    run_txn(1'b0 + 1'b1, 1'b0, 32'h0000_1003, 32'h0, 2'd0, 3'd2, 0, 32'h80FF_1234);
    // sb, 3 wait cycles (ack coincides with the timeout cycle: ack wins)
    run_txn(1'b0, 1'b1, 32'h0000_2002, 32'h1234_56AB, 2'd1, 3'd0, 3, 32'h0);
    // misaligned sh and lw
    run_txn(1'b0, 1'b1, 32'h0000_2001, 32'hDEAD_BEEF, 2'd2, 3'd0, 0, 32'h0);
    run_txn(1'b1, 1'b0, 32'h0000_2002, 32'h0, 2'd0, 3'd0, 0, 32'h0);
    // load timeout
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2'd0, 3'd0, 99, 32'h0);
    idle_cycle(1'b1);
    // read+write together behaves as a store
    run_txn(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 2'd0, 3'd1, 1, 32'h5555_5555);
    // sh upper half
    run_txn(1'b0, 1'b1, 32'h0000_3002, 32'h0000_BEEF, 2'd2, 3'd0, 2, 32'h0);

    // Reset during the second BUSY cycle abandons the transaction.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0000_0080; ld_op = 3'd0;
    #1;
    check_eq("rt_start", {31'd0, stall}, 32'd1);
    @(negedge clk);
    #1;
    check_eq("rt_busy1", {31'd0, bus.dm_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0;
    #1;
    exp_dmout = '0; exp_xaddr = '0; exp_xop = '0; xaddr_ok = 1'b1;
    check_eq("rt_req", {31'd0, bus.dm_req}, 32'd0);
    check_eq("rt_stall", {31'd0, stall}, 32'd0);
    check_xext();
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    for (int i = 0; i < 300; i++) begin
      logic rd, wr;
      int   w;
      rd = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      w  = $urandom_range(0, 5);
      run_txn(rd, wr, $urandom, $urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              w, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
